// File: rtl/counter_check_pkg.sv
// Shared types and defaults for the counter stream checker.
// Holds the checker state encoding, lock/miss defaults and a sizing helper.
package counter_check_pkg;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_MAX_MISS   = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/counter_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// When clear and increment coincide, the clear lands first and the result is 1.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] base;

  assign base = clr ? '0 : count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (base != '1)) begin
      count <= base + W'(1);
    end else begin
      count <= base;
    end
  end

endmodule

// File: rtl/counter_stream_checker.sv
// Receive-side checker for a free-running +1 counter stream: acquires lock,
// then flags, counts and captures the first discontinuity seen while locked.
import counter_check_pkg::*;

module counter_stream_checker #(
  parameter int WIDTH      = 8,
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int MAX_MISS   = DEF_MAX_MISS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_value,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_got,
  output logic [WIDTH-1:0]     first_exp
);

  localparam int RUN_W = $clog2(max_int(LOCK_COUNT, MAX_MISS) + 1);

  chk_state_t       state, state_nx;
  logic [WIDTH-1:0] expected, expected_nx;
  logic [RUN_W-1:0] good_run, good_nx;
  logic [RUN_W-1:0] miss_run, miss_nx;
  logic             match;
  logic             err_event;
  logic             capture;

  assign match = (in_value == expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNSYNC;
      expected <= '0;
      good_run <= '0;
      miss_run <= '0;
    end else begin
      state    <= state_nx;
      expected <= expected_nx;
      good_run <= good_nx;
      miss_run <= miss_nx;
    end
  end

  // NOTE: every always_comb output gets a default up front so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    expected_nx = expected;
    good_nx     = good_run;
    miss_nx     = miss_run;
    err_event   = 1'b0;
    if (in_valid) begin
      // Follow the stream: the next expected value always tracks the last sample.
      expected_nx = in_value + WIDTH'(1);
      unique case (state)
        UNSYNC: begin
          state_nx = ACQUIRE;
          good_nx  = RUN_W'(1);
        end
        ACQUIRE: begin
          if (match) begin
            good_nx = good_run + RUN_W'(1);
            if (good_run + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
              state_nx = LOCKED;
              miss_nx  = '0;
            end
          end else begin
            good_nx = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            miss_nx = '0;
          end else begin
            err_event = 1'b1;
            if (miss_run + RUN_W'(1) == RUN_W'(MAX_MISS)) begin
              state_nx = ACQUIRE;
              good_nx  = RUN_W'(1);
              miss_nx  = '0;
            end else begin
              miss_nx = miss_run + RUN_W'(1);
            end
          end
        end
        default: begin
          state_nx = UNSYNC;
          good_nx  = '0;
          miss_nx  = '0;
        end
      endcase
    end
  end

  // A clear in the same cycle empties the stats first, so this error becomes the first one.
  assign capture = err_event && (clear || !err_flag);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag  <= 1'b0;
      first_got <= '0;
      first_exp <= '0;
    end else begin
      if (err_event)  err_flag <= 1'b1;
      else if (clear) err_flag <= 1'b0;

      if (capture) begin
        first_got <= in_value;
        first_exp <= expected;
      end else if (clear) begin
        first_got <= '0;
        first_exp <= '0;
      end
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_event),
    .clr   (clear),
    .count (err_count)
  );

  assign locked = (state == LOCKED);

endmodule
